csr_access_ctrl: RTL and testbench
==================================

# csr_access_ctrl

Sequences and arbitrates every access to the CSR file. It accepts Zicsr read-modify-write requests from two requesters: the core's execute stage and an optional debug/host port. It grants one request at a time and runs it as a fixed read phase followed by a write phase on the CSR file's single read/write port. It returns the old CSR value and an illegal-access flag to the requester that issued the request.

## Interface
Parameters:
- `XLEN`, 32, CSR data width.
- `ADDR_W`, 12, CSR address width.

Ports:
- `clk`  in  1  global system clock.
- `rst_n`  in  1  global reset; synchronous, active-low.
- `core_req`  in  1  core request valid; held until `core_ack`.
- `core_op`  in  2  00=RW, 01=RS, 10=RC, 11=reserved.
- `core_addr`  in  ADDR_W  CSR address.
- `core_wdata`  in  XLEN  rs1/uimm operand.
- `core_rd_suppress`  in  1  rd==x0 on RW; the read is not explicit.
- `core_wr_suppress`  in  1  operand register is x0 on RS/RC; no write.
- `core_flush`  in  1  cancel the in-flight core access.
- `core_ack`  out  1  one-cycle completion pulse.
- `core_rdata`  out  XLEN  old CSR value; valid with `core_ack`.
- `core_illegal`  out  1  illegal access; valid with `core_ack`.
- `dbg_req`, `dbg_op`, `dbg_addr`, `dbg_wdata`  in  1/2/ADDR_W/XLEN  debug request; same semantics as the core fields; no suppress inputs.
- `dbg_ack`  out  1  debug completion pulse.
- `dbg_rdata`  out  XLEN  debug read data; valid with `dbg_ack`.
- `dbg_err`  out  1  debug illegal flag; valid with `dbg_ack`.
- `csr_rd_en`, `csr_explicit_rd`, `csr_wr_en`  out  1  CSR file strobes.
- `csr_addr`  out  ADDR_W  CSR file address.
- `csr_wr_data`  out  XLEN  CSR file write data.
- `csr_rd_data`  in  XLEN  combinational read data from the CSR file.
- `csr_illegal`  in  1  combinational illegal flag from the CSR file.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - If any request is valid, arbitrate, latch op/addr/wdata/suppress bits and the owner, then go to READ.
  - Arbitration is round-robin: with both requests valid, grant the requester that was not granted last.
  - The `last` register resets to debug, so the core wins the first tie.
- READ:
  - Drive `csr_addr`.
  - `csr_rd_en` = 1.
  - `csr_explicit_rd` = !rd_suppress; debug reads are always explicit.
  - Capture `csr_rd_data` and `csr_illegal` into registers.
  - If the captured illegal flag is set or op==11, set the illegal result, force the captured rdata to 0, and go to RESP.
  - Otherwise go to WRITE.
- WRITE:
  - New value: RW: wdata; RS: old | wdata; RC: old & ~wdata.
  - `csr_wr_en` = !wr_suppress; `csr_wr_data` = new value.
  - Always go to RESP.
- RESP:
  - Pulse the owner's ack with the registered rdata and illegal flag.
  - The other requester's outputs remain 0.
  - Update `last` to the owner and return to IDLE.
- Flush:
  - `core_flush` in READ with owner=core: abort to IDLE with no write and no ack. `last` is still updated.
  - Flush in IDLE, WRITE or RESP is ignored. In WRITE and RESP the write has committed.
- Request fields are sampled only at grant. A requester deasserting `req` after grant does not cancel the access.

## Timing
- The request is sampled in IDLE at edge N; READ runs in cycle N+1, WRITE in N+2, and ack is high in N+3.
- An illegal access skips WRITE, so ack is high in N+2.
- Back-to-back: the next grant is sampled in the IDLE cycle following RESP. Minimum spacing between accesses is 4 cycles.
- `csr_rd_en` and `csr_wr_en` are never high in the same cycle.
- All strobes are 0 outside READ and WRITE; `csr_addr` and `csr_wr_data` are 0 in IDLE.
- Reset value of every output is 0. The FSM returns to IDLE and `last` returns to debug.
- `rst_n` low in any state aborts the access with no ack and no further strobes from the next cycle.
- A CSR write lands at the edge ending WRITE. A subsequent access reads the new value.

## Configuration
- `CSR_DEBUG_PORT_EN`, when defined: the debug port and round-robin arbitration are present.
- When undefined:
  - `dbg_*` inputs are ignored and `dbg_ack`, `dbg_rdata`, `dbg_err` are tied 0.
  - Only the core is granted; the `last` register is removed.
  - Latency and all core behaviour are unchanged.

## Test plan
- Core RS: `mscratch`=0x0000_00F0, `core_op`=01, `core_wdata`=0x0F → `csr_rd_en` in N+1, `csr_wr_en` in N+2 with data 0xFF, `core_ack` in N+3 with `core_rdata`=0xF0.
- Core RC with `core_wr_suppress`=1 on `mstatus` → `csr_wr_en` stays 0 throughout, and `core_rdata` returns the current `mstatus`.
- Access to unimplemented address 0x7C0 → no WRITE state, ack in N+2 with `core_illegal`=1 and `core_rdata`=0.
- Both requests held from reset (debug enabled) → grant order core, debug, core, debug, with acks spaced 4 cycles apart.
- `core_flush` during READ of RW 0x340 → no `csr_wr_en`, no `core_ack`, and `mscratch` unchanged; a pending `dbg_req` is granted in the next IDLE cycle.
- `rst_n` low during WRITE → all outputs 0 next cycle; after release, a fresh request completes normally in 3 cycles.

Source files
------------

// File: rtl/csr_access_ctrl_if.sv
// Request/response and CSR-file port bundle for csr_access_ctrl.
// slave = the access controller, master = requesters plus CSR file side.
interface csr_access_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
);
    logic              core_req;
    logic [1:0]        core_op;
    logic [ADDR_W-1:0] core_addr;
    logic [XLEN-1:0]   core_wdata;
    logic              core_rd_suppress;
    logic              core_wr_suppress;
    logic              core_flush;
    logic              core_ack;
    logic [XLEN-1:0]   core_rdata;
    logic              core_illegal;

    logic              dbg_req;
    logic [1:0]        dbg_op;
    logic [ADDR_W-1:0] dbg_addr;
    logic [XLEN-1:0]   dbg_wdata;
    logic              dbg_ack;
    logic [XLEN-1:0]   dbg_rdata;
    logic              dbg_err;

    logic              csr_rd_en;
    logic              csr_explicit_rd;
    logic              csr_wr_en;
    logic [ADDR_W-1:0] csr_addr;
    logic [XLEN-1:0]   csr_wr_data;
    logic [XLEN-1:0]   csr_rd_data;
    logic              csr_illegal;

    // Handshake: a requester holds req (and its fields) high until it sees
    // its one-cycle ack; fields are sampled only on the grant edge.
    modport slave (
        input  core_req, core_op, core_addr, core_wdata,
               core_rd_suppress, core_wr_suppress, core_flush,
        output core_ack, core_rdata, core_illegal,
        input  dbg_req, dbg_op, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata, dbg_err,
        output csr_rd_en, csr_explicit_rd, csr_wr_en, csr_addr, csr_wr_data,
        input  csr_rd_data, csr_illegal
    );

    modport master (
        output core_req, core_op, core_addr, core_wdata,
               core_rd_suppress, core_wr_suppress, core_flush,
        input  core_ack, core_rdata, core_illegal,
        output dbg_req, dbg_op, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata, dbg_err,
        input  csr_rd_en, csr_explicit_rd, csr_wr_en, csr_addr, csr_wr_data,
        output csr_rd_data, csr_illegal
    );
endinterface

// File: rtl/csr_access_ctrl.sv
// CSR access sequencer: arbitrates core/debug Zicsr requests and runs each as READ then WRITE.
// Define CSR_DEBUG_PORT_EN to enable the debug requester and round-robin arbitration.
module csr_access_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    csr_access_ctrl_if.slave      bus,
    output logic [1:0]            o_state
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_owner_dbg;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic              r_rd_sup;
    logic              r_wr_sup;
    logic [XLEN-1:0]   r_rdata;
    logic              r_illegal;

    logic              w_any_req;
    logic              w_grant_dbg;
    logic              w_flush_abort;
    logic              w_rd_illegal;
    logic [XLEN-1:0]   w_new;

`ifdef CSR_DEBUG_PORT_EN
    logic r_last_dbg;
    // Round-robin: on a tie the requester not served last wins.
    assign w_grant_dbg = bus.dbg_req && (!bus.core_req || !r_last_dbg);
    assign w_any_req   = bus.core_req || bus.dbg_req;
`else
    logic w_dbg_unused;
    assign w_dbg_unused = ^{bus.dbg_req, bus.dbg_op, bus.dbg_addr, bus.dbg_wdata};
    assign w_grant_dbg  = 1'b0;
    assign w_any_req    = bus.core_req;
`endif

    assign w_flush_abort = (r_state == ST_READ) && !r_owner_dbg && bus.core_flush;
    assign w_rd_illegal  = bus.csr_illegal || (r_op == 2'b11);
    assign o_state       = r_state;

    always_comb begin
        w_new = r_wdata;
        case (r_op)
            2'b01:   w_new = r_rdata | r_wdata;
            2'b10:   w_new = r_rdata & ~r_wdata;
            default: w_new = r_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_req) w_next = ST_READ;
            ST_READ: begin
                if (w_flush_abort)     w_next = ST_IDLE;
                else if (w_rd_illegal) w_next = ST_RESP;
                else                   w_next = ST_WRITE;
            end
            ST_WRITE: w_next = ST_RESP;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner_dbg <= 1'b0;
            r_op        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rd_sup    <= 1'b0;
            r_wr_sup    <= 1'b0;
            r_rdata     <= '0;
            r_illegal   <= 1'b0;
`ifdef CSR_DEBUG_PORT_EN
            r_last_dbg  <= 1'b1;
`endif
        end else begin
            if (r_state == ST_IDLE && w_any_req) begin
                r_owner_dbg <= w_grant_dbg;
`ifdef CSR_DEBUG_PORT_EN
                r_op     <= w_grant_dbg ? bus.dbg_op    : bus.core_op;
                r_addr   <= w_grant_dbg ? bus.dbg_addr  : bus.core_addr;
                r_wdata  <= w_grant_dbg ? bus.dbg_wdata : bus.core_wdata;
`else
                r_op     <= bus.core_op;
                r_addr   <= bus.core_addr;
                r_wdata  <= bus.core_wdata;
`endif
                // Debug accesses have no suppress inputs: always explicit read and write.
                r_rd_sup <= !w_grant_dbg && bus.core_rd_suppress;
                r_wr_sup <= !w_grant_dbg && bus.core_wr_suppress;
            end
            if (r_state == ST_READ) begin
                r_rdata   <= w_rd_illegal ? '0 : bus.csr_rd_data;
                r_illegal <= w_rd_illegal;
            end
`ifdef CSR_DEBUG_PORT_EN
            if (r_state == ST_RESP || w_flush_abort) begin
                r_last_dbg <= r_owner_dbg;
            end
`endif
        end
    end

    always_comb begin
        bus.core_ack        = 1'b0;
        bus.core_rdata      = '0;
        bus.core_illegal    = 1'b0;
        bus.dbg_ack         = 1'b0;
        bus.dbg_rdata       = '0;
        bus.dbg_err         = 1'b0;
        bus.csr_rd_en       = 1'b0;
        bus.csr_explicit_rd = 1'b0;
        bus.csr_wr_en       = 1'b0;
        bus.csr_addr        = '0;
        bus.csr_wr_data     = '0;
        case (r_state)
            ST_READ: begin
                bus.csr_rd_en       = 1'b1;
                bus.csr_explicit_rd = !r_rd_sup;
                bus.csr_addr        = r_addr;
            end
            ST_WRITE: begin
                bus.csr_wr_en   = !r_wr_sup;
                bus.csr_addr    = r_addr;
                bus.csr_wr_data = w_new;
            end
            ST_RESP: begin
`ifdef CSR_DEBUG_PORT_EN
                if (r_owner_dbg) begin
                    bus.dbg_ack   = 1'b1;
                    bus.dbg_rdata = r_rdata;
                    bus.dbg_err   = r_illegal;
                end else begin
                    bus.core_ack     = 1'b1;
                    bus.core_rdata   = r_rdata;
                    bus.core_illegal = r_illegal;
                end
`else
                bus.core_ack     = 1'b1;
                bus.core_rdata   = r_rdata;
                bus.core_illegal = r_illegal;
`endif
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl with a small CSR file model.
// Scoreboard entries are {owner_is_dbg, illegal, rdata}.
module tb_csr_access_ctrl;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 12;
    localparam int W      = XLEN + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state;

    csr_access_ctrl_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus();

    csr_access_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .o_state (state)
    );

    always #5 clk = ~clk;

    // CSR file: mstatus 0x300, mscratch 0x340, mtvec 0x305, mepc 0x341
    logic [XLEN-1:0] csr_mem [4] = '{32'h0000_1888, 32'h0000_00F0, 32'h0000_0100, 32'h0};
    logic [XLEN-1:0] shadow  [4] = '{32'h0000_1888, 32'h0000_00F0, 32'h0000_0100, 32'h0};
    logic [W-1:0]    exp_q [$];
    int total = 0;
    int bad   = 0;

    function automatic int csr_idx(input logic [ADDR_W-1:0] a);
        case (a)
            12'h300: return 0;
            12'h340: return 1;
            12'h305: return 2;
            12'h341: return 3;
            default: return -1;
        endcase
    endfunction

    always_comb begin
        bus.csr_rd_data = '0;
        bus.csr_illegal = 1'b1;
        case (bus.csr_addr)
            12'h300: begin bus.csr_rd_data = csr_mem[0]; bus.csr_illegal = 1'b0; end
            12'h340: begin bus.csr_rd_data = csr_mem[1]; bus.csr_illegal = 1'b0; end
            12'h305: begin bus.csr_rd_data = csr_mem[2]; bus.csr_illegal = 1'b0; end
            12'h341: begin bus.csr_rd_data = csr_mem[3]; bus.csr_illegal = 1'b0; end
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (bus.csr_wr_en) begin
            case (bus.csr_addr)
                12'h300: csr_mem[0] <= bus.csr_wr_data;
                12'h340: csr_mem[1] <= bus.csr_wr_data;
                12'h305: csr_mem[2] <= bus.csr_wr_data;
                12'h341: csr_mem[3] <= bus.csr_wr_data;
                default: ;
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        total++; if ({bus.core_ack, bus.dbg_ack, bus.core_illegal, bus.dbg_err} !== 4'b0) begin
            bad++; $display("FAIL reset_acks: got %b want 0000", {bus.core_ack, bus.dbg_ack, bus.core_illegal, bus.dbg_err}); end
        total++; if ({bus.csr_rd_en, bus.csr_wr_en, bus.csr_explicit_rd} !== 3'b0) begin
            bad++; $display("FAIL reset_strobes: got %b want 000", {bus.csr_rd_en, bus.csr_wr_en, bus.csr_explicit_rd}); end
        total++; if ({bus.csr_addr, bus.csr_wr_data, bus.core_rdata, bus.dbg_rdata} !== '0) begin
            bad++; $display("FAIL reset_data: got %h %h %h %h want 0", bus.csr_addr, bus.csr_wr_data, bus.core_rdata, bus.dbg_rdata); end
        rst_n = 1'b1;
    endtask

    // Drives one core access and checks every cycle of it; call at a negedge.
    task automatic run_core_access(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                                   input logic [XLEN-1:0] wd, input logic rs, input logic ws);
        int k;
        logic legal;
        logic [XLEN-1:0] old, nv;
        logic [W-1:0] e;
        k     = csr_idx(addr);
        legal = (k >= 0) && (op != 2'b11);
        old   = legal ? shadow[k[1:0]] : '0;
        case (op)
            2'b00:   nv = wd;
            2'b01:   nv = old | wd;
            2'b10:   nv = old & ~wd;
            default: nv = old;
        endcase
        exp_q.push_back({1'b0, !legal, old});
        if (legal && !ws) shadow[k[1:0]] = nv;
        bus.core_req = 1'b1; bus.core_op = op; bus.core_addr = addr; bus.core_wdata = wd;
        bus.core_rd_suppress = rs; bus.core_wr_suppress = ws;
        @(negedge clk);
        total++; if (state !== 2'd1) begin bad++; $display("FAIL read_state: got %0d want 1", state); end
        total++; if (bus.csr_rd_en !== 1'b1 || bus.csr_wr_en !== 1'b0) begin
            bad++; $display("FAIL read_strobes: got rd=%b wr=%b want rd=1 wr=0", bus.csr_rd_en, bus.csr_wr_en); end
        total++; if (bus.csr_addr !== addr) begin bad++; $display("FAIL read_addr: got %h want %h", bus.csr_addr, addr); end
        total++; if (bus.csr_explicit_rd !== !rs) begin bad++; $display("FAIL explicit_rd: got %b want %b", bus.csr_explicit_rd, !rs); end
        @(negedge clk);
        if (legal) begin
            total++; if (state !== 2'd2 || bus.core_ack !== 1'b0) begin
                bad++; $display("FAIL write_state: got %0d ack=%b want 2 ack=0", state, bus.core_ack); end
            total++; if (bus.csr_wr_en !== !ws || bus.csr_rd_en !== 1'b0) begin
                bad++; $display("FAIL write_strobes: got wr=%b rd=%b want wr=%b rd=0", bus.csr_wr_en, bus.csr_rd_en, !ws); end
            if (!ws) begin
                total++; if (bus.csr_wr_data !== nv) begin bad++; $display("FAIL write_data: got %h want %h", bus.csr_wr_data, nv); end
            end
            @(negedge clk);
        end
        total++; if (bus.core_ack !== 1'b1 || bus.dbg_ack !== 1'b0) begin
            bad++; $display("FAIL ack_latency: got core=%b dbg=%b want core=1 dbg=0", bus.core_ack, bus.dbg_ack); end
        total++; if (bus.csr_wr_en !== 1'b0 || bus.csr_rd_en !== 1'b0) begin
            bad++; $display("FAIL resp_strobes: got rd=%b wr=%b want 0 0", bus.csr_rd_en, bus.csr_wr_en); end
        total++;
        if (exp_q.size() == 0) begin
            bad++; $display("FAIL sb_empty: got ack want none");
        end else begin
            e = exp_q.pop_front();
            if (bus.core_rdata !== e[XLEN-1:0] || bus.core_illegal !== e[XLEN]) begin
                bad++; $display("FAIL core_result: got %h ill=%b want %h ill=%b", bus.core_rdata, bus.core_illegal, e[XLEN-1:0], e[XLEN]);
            end
        end
        bus.core_req = 1'b0;
        @(negedge clk);
        total++; if (state !== 2'd0 || bus.csr_addr !== '0 || bus.csr_wr_data !== '0) begin
            bad++; $display("FAIL idle_outputs: got st=%0d addr=%h wd=%h want 0", state, bus.csr_addr, bus.csr_wr_data); end
    endtask

    task automatic test_core_rs();
        run_core_access(2'b01, 12'h340, 32'h0F, 1'b0, 1'b0);
        total++; if (csr_mem[1] !== 32'hFF) begin bad++; $display("FAIL rs_landed: got %h want 000000ff", csr_mem[1]); end
    endtask

    task automatic test_core_rc_suppress();
        run_core_access(2'b10, 12'h300, 32'h8, 1'b0, 1'b1);
        total++; if (csr_mem[0] !== shadow[0]) begin bad++; $display("FAIL rc_sup_mem: got %h want %h", csr_mem[0], shadow[0]); end
    endtask

    task automatic test_illegal();
        run_core_access(2'b01, 12'h7C0, 32'h5, 1'b0, 1'b0);
        run_core_access(2'b11, 12'h340, 32'h1, 1'b0, 1'b0);
    endtask

    task automatic test_readback();
        run_core_access(2'b00, 12'h305, 32'h2000, 1'b1, 1'b0);
        run_core_access(2'b01, 12'h305, 32'h0, 1'b0, 1'b0);
        run_core_access(2'b10, 12'h340, 32'h0F, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++; if (csr_mem[i] !== shadow[i]) begin bad++; $display("FAIL mem_%0d: got %h want %h", i, csr_mem[i], shadow[i]); end
        end
    endtask

`ifdef CSR_DEBUG_PORT_EN
    task automatic test_round_robin();
        int acks, last_cyc, cyc;
        logic [W-1:0] e;
        logic [XLEN-1:0] got;
        rst_n = 1'b0;
        bus.core_req = 1'b1; bus.core_op = 2'b01; bus.core_addr = 12'h340; bus.core_wdata = 32'h100;
        bus.core_rd_suppress = 1'b0; bus.core_wr_suppress = 1'b0;
        bus.dbg_req = 1'b1; bus.dbg_op = 2'b00; bus.dbg_addr = 12'h341; bus.dbg_wdata = 32'hABCD;
        exp_q.push_back({1'b0, 1'b0, shadow[1]}); shadow[1] = shadow[1] | 32'h100;
        exp_q.push_back({1'b1, 1'b0, shadow[3]}); shadow[3] = 32'hABCD;
        exp_q.push_back({1'b0, 1'b0, shadow[1]});
        exp_q.push_back({1'b1, 1'b0, shadow[3]});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acks = 0; last_cyc = 0; cyc = 0;
        while (acks < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            total++; if (bus.csr_rd_en && bus.csr_wr_en) begin bad++; $display("FAIL rd_wr_overlap: got 11 want not both"); end
            if (bus.core_ack || bus.dbg_ack) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rr_sb_empty: got ack want none");
                end else begin
                    e = exp_q.pop_front();
                    got = bus.dbg_ack ? bus.dbg_rdata : bus.core_rdata;
                    if (bus.dbg_ack !== e[XLEN+1] || bus.core_ack === bus.dbg_ack || got !== e[XLEN-1:0]) begin
                        bad++; $display("FAIL rr_grant%0d: got dbg=%b core=%b data=%h want dbg=%b data=%h",
                                        acks, bus.dbg_ack, bus.core_ack, got, e[XLEN+1], e[XLEN-1:0]);
                    end
                end
                total++;
                if (cyc - last_cyc !== (acks == 0 ? 3 : 4)) begin
                    bad++; $display("FAIL rr_spacing%0d: got %0d want %0d", acks, cyc - last_cyc, acks == 0 ? 3 : 4);
                end
                last_cyc = cyc;
                acks++;
                if (acks == 4) begin bus.core_req = 1'b0; bus.dbg_req = 1'b0; end
            end
        end
        total++; if (acks != 4) begin bad++; $display("FAIL rr_timeout: got %0d acks want 4", acks); end
        @(negedge clk);
    endtask
`else
    task automatic test_dbg_ignored();
        bus.dbg_req = 1'b1; bus.dbg_op = 2'b00; bus.dbg_addr = 12'h340; bus.dbg_wdata = 32'h1234;
        repeat (4) begin
            @(negedge clk);
            total++; if (state !== 2'd0 || bus.csr_rd_en !== 1'b0 || bus.dbg_ack !== 1'b0 || bus.dbg_rdata !== '0) begin
                bad++; $display("FAIL dbg_ignored: got st=%0d rd=%b ack=%b want 0", state, bus.csr_rd_en, bus.dbg_ack); end
        end
        bus.dbg_req = 1'b0;
    endtask
`endif

    task automatic test_flush();
        logic [W-1:0] e;
        bus.core_req = 1'b1; bus.core_op = 2'b00; bus.core_addr = 12'h340; bus.core_wdata = 32'hDEAD;
        bus.core_rd_suppress = 1'b0; bus.core_wr_suppress = 1'b0;
`ifdef CSR_DEBUG_PORT_EN
        bus.dbg_req = 1'b1; bus.dbg_op = 2'b01; bus.dbg_addr = 12'h340; bus.dbg_wdata = 32'h0;
        exp_q.push_back({1'b1, 1'b0, shadow[1]});
`endif
        @(negedge clk);
        total++; if (state !== 2'd1 || bus.csr_addr !== 12'h340) begin
            bad++; $display("FAIL flush_read: got st=%0d addr=%h want 1 340", state, bus.csr_addr); end
        bus.core_flush = 1'b1; bus.core_req = 1'b0;
        @(negedge clk);
        bus.core_flush = 1'b0;
        total++; if (state !== 2'd0 || bus.csr_wr_en !== 1'b0 || bus.core_ack !== 1'b0) begin
            bad++; $display("FAIL flush_abort: got st=%0d wr=%b ack=%b want 0 0 0", state, bus.csr_wr_en, bus.core_ack); end
        total++; if (csr_mem[1] !== shadow[1]) begin bad++; $display("FAIL flush_mem: got %h want %h", csr_mem[1], shadow[1]); end
        @(negedge clk);
`ifdef CSR_DEBUG_PORT_EN
        total++; if (state !== 2'd1 || bus.csr_rd_en !== 1'b1 || bus.csr_explicit_rd !== 1'b1) begin
            bad++; $display("FAIL flush_dbg_grant: got st=%0d rd=%b ex=%b want 1 1 1", state, bus.csr_rd_en, bus.csr_explicit_rd); end
        @(negedge clk);
        total++; if (bus.csr_wr_en !== 1'b1 || bus.csr_wr_data !== shadow[1]) begin
            bad++; $display("FAIL dbg_write: got wr=%b %h want 1 %h", bus.csr_wr_en, bus.csr_wr_data, shadow[1]); end
        @(negedge clk);
        total++;
        if (exp_q.size() == 0) begin
            bad++; $display("FAIL dbg_sb_empty: got ack want none");
        end else begin
            e = exp_q.pop_front();
            if (bus.dbg_ack !== 1'b1 || bus.core_ack !== 1'b0 || bus.dbg_rdata !== e[XLEN-1:0] || bus.dbg_err !== e[XLEN]) begin
                bad++; $display("FAIL dbg_result: got ack=%b %h err=%b want ack=1 %h err=%b",
                                bus.dbg_ack, bus.dbg_rdata, bus.dbg_err, e[XLEN-1:0], e[XLEN]);
            end
        end
        bus.dbg_req = 1'b0;
        @(negedge clk);
`else
        total++; if (state !== 2'd0 || bus.core_ack !== 1'b0) begin
            bad++; $display("FAIL flush_no_regrant: got st=%0d ack=%b want 0 0", state, bus.core_ack); end
`endif
    endtask

    task automatic test_reset_in_write();
        bus.core_req = 1'b1; bus.core_op = 2'b10; bus.core_addr = 12'h305; bus.core_wdata = 32'h0;
        bus.core_rd_suppress = 1'b0; bus.core_wr_suppress = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (state !== 2'd2) begin bad++; $display("FAIL rst_pre_write: got %0d want 2", state); end
        rst_n = 1'b0; bus.core_req = 1'b0;
        @(negedge clk);
        total++; if (state !== 2'd0 || {bus.core_ack, bus.csr_rd_en, bus.csr_wr_en, bus.core_illegal} !== 4'b0
                     || bus.csr_addr !== '0 || bus.csr_wr_data !== '0 || bus.core_rdata !== '0) begin
            bad++; $display("FAIL rst_in_write: got st=%0d ack=%b rd=%b wr=%b addr=%h want all 0",
                            state, bus.core_ack, bus.csr_rd_en, bus.csr_wr_en, bus.csr_addr); end
        rst_n = 1'b1;
        run_core_access(2'b01, 12'h305, 32'h1, 1'b0, 1'b0);
    endtask

    initial begin
        bus.core_req = 1'b0; bus.core_op = 2'b00; bus.core_addr = '0; bus.core_wdata = '0;
        bus.core_rd_suppress = 1'b0; bus.core_wr_suppress = 1'b0; bus.core_flush = 1'b0;
        bus.dbg_req = 1'b0; bus.dbg_op = 2'b00; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        test_reset();
        @(negedge clk);
        test_core_rs();
        test_core_rc_suppress();
        test_illegal();
        test_readback();
`ifdef CSR_DEBUG_PORT_EN
        test_round_robin();
`else
        test_dbg_ignored();
`endif
        test_flush();
        test_reset_in_write();
        for (int i = 0; i < 8; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 2));
            run_core_access(op, 12'h341, $urandom, 1'b0, 1'($urandom_range(0, 1)));
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
